// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Single-entry decode/issue pipeline register in front of the
//               ALU. Accepts one RV32I instruction per valid/ready handshake,
//               decodes it and presents registered opcode/funct fields, ALU
//               operands, writeback target and control-flow side information.
//               Supports downstream stall and upstream flush.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    // upstream handshake
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    // downstream handshake
    output logic        out_valid,
    input  logic        out_ready,
    // decoded, registered results
    output logic [6:0]  opcode_reg,
    output logic [2:0]  funct3_reg,
    output logic [6:0]  funct7_reg,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [4:0]  rd_reg,
    output logic        reg_write,
    output logic [31:0] store_data,
    output logic [31:0] link_addr,
    output logic [31:0] target_addr,
    output logic        illegal
);

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // OP-IMM funct3 codes that carry a shift amount instead of an immediate
    localparam logic [2:0] c_F3_SLLI   = 3'b001;
    localparam logic [2:0] c_F3_SRXI   = 3'b101;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7_raw;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;

    assign w_opcode     = instr[6:0];
    assign w_funct3     = instr[14:12];
    assign w_funct7_raw = instr[31:25];
    assign w_rd         = instr[11:7];
    assign w_shamt      = instr[24:20];

    // ------------------------------------------------------------------------
    // Sign-extended immediates
    // ------------------------------------------------------------------------
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic r_out_valid;
    logic w_in_ready;
    logic w_load;

    // The slot can take a new instruction when empty or when it drains this
    // same cycle; a flush blocks acceptance so the incoming word is dropped.
    assign w_in_ready = !flush && (!r_out_valid || out_ready);
    assign w_load     = in_valid && w_in_ready;

    // ------------------------------------------------------------------------
    // Decode: operand select, writeback and side information
    // ------------------------------------------------------------------------
    logic [6:0]  w_funct7;
    logic [31:0] w_src_a;
    logic [31:0] w_src_b;
    logic        w_writes_rd;
    logic [31:0] w_store_data;
    logic [31:0] w_target_addr;
    logic        w_illegal;
    logic [31:0] w_link_addr;

    assign w_link_addr = pc + 32'd4;

    // Opcode-driven operand and control decode; unknown opcodes issue as a
    // harmless zero-operand, non-writing instruction flagged illegal.
    always_comb begin
        w_funct7      = 7'b0;
        w_src_a       = 32'b0;
        w_src_b       = 32'b0;
        w_writes_rd   = 1'b0;
        w_store_data  = 32'b0;
        w_target_addr = 32'b0;
        w_illegal     = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_src_a     = rs1_data;
                w_src_b     = rs2_data;
                w_funct7    = w_funct7_raw;
                w_writes_rd = 1'b1;
            end
            c_OP_IMM: begin
                w_src_a     = rs1_data;
                w_writes_rd = 1'b1;
                if (w_funct3 == c_F3_SLLI || w_funct3 == c_F3_SRXI) begin
                    // shifts keep funct7 so SRAI is distinguishable from SRLI
                    w_src_b  = {27'b0, w_shamt};
                    w_funct7 = w_funct7_raw;
                end else begin
                    // upper immediate bits must not look like SUB to the ALU
                    w_src_b  = w_imm_i;
                    w_funct7 = 7'b0;
                end
            end
            c_OP_LOAD: begin
                w_src_a     = rs1_data;
                w_src_b     = w_imm_i;
                w_writes_rd = 1'b1;
            end
            c_OP_JALR: begin
                w_src_a     = rs1_data;
                w_src_b     = w_imm_i;
                w_writes_rd = 1'b1;
            end
            c_OP_STORE: begin
                w_src_a      = rs1_data;
                w_src_b      = w_imm_s;
                w_store_data = rs2_data;
            end
            c_OP_BRANCH: begin
                w_src_a       = rs1_data;
                w_src_b       = rs2_data;
                w_target_addr = pc + w_imm_b;
            end
            c_OP_JAL: begin
                w_src_a     = pc;
                w_src_b     = w_imm_j;
                w_writes_rd = 1'b1;
            end
            c_OP_LUI: begin
                w_src_a     = 32'b0;
                w_src_b     = w_imm_u;
                w_writes_rd = 1'b1;
            end
            c_OP_AUIPC: begin
                w_src_a     = pc;
                w_src_b     = w_imm_u;
                w_writes_rd = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_src_a;
    logic [31:0] r_src_b;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [31:0] r_store_data;
    logic [31:0] r_link_addr;
    logic [31:0] r_target_addr;
    logic        r_illegal;

    // Valid flag: reset beats flush, flush beats any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Payload: captured only on an accepted transfer, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode      <= 7'b0;
            r_funct3      <= 3'b0;
            r_funct7      <= 7'b0;
            r_src_a       <= 32'b0;
            r_src_b       <= 32'b0;
            r_rd          <= 5'b0;
            r_reg_write   <= 1'b0;
            r_store_data  <= 32'b0;
            r_link_addr   <= 32'b0;
            r_target_addr <= 32'b0;
            r_illegal     <= 1'b0;
        end else if (w_load) begin
            r_opcode      <= w_opcode;
            r_funct3      <= w_funct3;
            r_funct7      <= w_funct7;
            r_src_a       <= w_src_a;
            r_src_b       <= w_src_b;
            r_rd          <= w_rd;
            r_reg_write   <= w_writes_rd && (w_rd != 5'd0);
            r_store_data  <= w_store_data;
            r_link_addr   <= w_link_addr;
            r_target_addr <= w_target_addr;
            r_illegal     <= w_illegal;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign opcode_reg  = r_opcode;
    assign funct3_reg  = r_funct3;
    assign funct7_reg  = r_funct7;
    assign SrcA        = r_src_a;
    assign SrcB        = r_src_b;
    assign rd_reg      = r_rd;
    assign reg_write   = r_reg_write;
    assign store_data  = r_store_data;
    assign link_addr   = r_link_addr;
    assign target_addr = r_target_addr;
    assign illegal     = r_illegal;

endmodule
`default_nettype wire
